// File: rtl/gc_response_serializer_pkg.sv
// Shared GameCube link definitions: timing in microseconds, standard response widths, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package gc_response_serializer_pkg;

    // Pulse-width timing of the GC one-wire link, in microseconds.
    localparam int GC_BIT_US          = 4;
    localparam int GC_SHORT_US        = 1;
    localparam int GC_LONG_US         = 3;
    localparam int GC_STOP_US_DEFAULT = 2;

    // Standard controller response lengths in bits.
    localparam int GC_RESP_W_ID     = 24;
    localparam int GC_RESP_W_POLL   = 64;
    localparam int GC_RESP_W_ORIGIN = 80;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TURNAROUND = 3'd1,
        ST_BIT_LOW    = 3'd2,
        ST_BIT_HIGH   = 3'd3,
        ST_STOP       = 3'd4,
        ST_DONE       = 3'd5
    } gc_state_e;

    function automatic logic [15:0] gc_us_to_clks(input int us, input int clks_per_us);
        return 16'(us * clks_per_us);
    endfunction

endpackage

// File: rtl/gc_response_serializer_phase.sv
// Loadable phase down-counter; tc_o flags the last cycle of a phase of load_val_i cycles.
// Latency: a phase loaded with N lasts exactly N cycles (tc_o high on the Nth).
// Backpressure: none; a load always wins over counting.
// Ports: CLK/RESET (sync, active-low), load_i + load_val_i start a phase, tc_o terminal count.
module gc_phase_timer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic        tc_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            // Count N-1 down to 0 so the phase spans N cycles including the load cycle's successor.
            cnt_d = (load_val_i == 16'd0) ? 16'd0 : 16'(load_val_i - 16'd1);
        end else if (cnt_q != 16'd0) begin
            cnt_d = 16'(cnt_q - 16'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 16'd0);

endmodule

// File: rtl/gc_response_serializer.sv
// GameCube response transmitter: on a CMD_DONE rise, sends TX_BUFFER MSB-first as GC pulse-width bits plus stop bit.
// Latency: first DRIVE_LOW one cycle after turnaround; TX_DONE at latch + T + 4us*bits + stop + 1 cycles.
// Backpressure: none; CMD_DONE rises while busy are dropped, not queued.
// Ports: CLK, RESET (sync, active-low), CMD_DONE level, TX_BUFFER/TX_BIT_TOTAL data,
//        DRIVE_LOW open-drain enable, BUSY while a response is in flight, TX_DONE completion pulse.
module gc_response_serializer
    import gc_response_serializer_pkg::*;
#(
    parameter int TX_BUFFER_WIDTH = GC_RESP_W_ORIGIN,
    parameter int CLKS_PER_US     = 40,
    parameter int TURNAROUND_US   = 2,
    parameter int STOP_LOW_US     = GC_STOP_US_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CMD_DONE,
    input  logic [TX_BUFFER_WIDTH-1:0] TX_BUFFER,
    input  logic [7:0]                 TX_BIT_TOTAL,
    output logic                       DRIVE_LOW,
    output logic                       BUSY,
    output logic                       TX_DONE
);

    localparam logic [15:0] TURN_CYC  = gc_us_to_clks(TURNAROUND_US, CLKS_PER_US);
    localparam logic [15:0] SHORT_CYC = gc_us_to_clks(GC_SHORT_US, CLKS_PER_US);
    localparam logic [15:0] LONG_CYC  = gc_us_to_clks(GC_LONG_US, CLKS_PER_US);
    localparam logic [15:0] BIT_CYC   = gc_us_to_clks(GC_BIT_US, CLKS_PER_US);
    localparam logic [15:0] STOP_CYC  = gc_us_to_clks(STOP_LOW_US, CLKS_PER_US);
    localparam int          MSB       = TX_BUFFER_WIDTH - 1;

    gc_state_e                  state_q, state_d;
    logic [TX_BUFFER_WIDTH-1:0] shift_q, shift_d;
    logic [7:0]                 bits_left_q, bits_left_d;
    logic                       cmd_prev_q;
    logic                       armed_q;
    logic                       drive_low_q, busy_q, tx_done_q;

    logic                       start_edge;
    logic [7:0]                 total_clamped;
    logic [TX_BUFFER_WIDTH-1:0] shift_next;
    logic [15:0]                low_cur, low_next;
    logic                       tmr_load;
    logic [15:0]                tmr_val;
    logic                       tmr_tc;

    // armed_q blocks a start until CMD_DONE has been seen low after reset, so a level
    // left high across reset cannot masquerade as a fresh rise.
    assign start_edge    = CMD_DONE & ~cmd_prev_q & armed_q;
    assign total_clamped = (int'(TX_BIT_TOTAL) > TX_BUFFER_WIDTH) ? 8'(TX_BUFFER_WIDTH) : TX_BIT_TOTAL;
    assign shift_next    = shift_q << 1;
    assign low_cur       = shift_q[MSB]    ? SHORT_CYC : LONG_CYC;
    assign low_next      = shift_next[MSB] ? SHORT_CYC : LONG_CYC;

    gc_phase_timer u_phase (
        .CLK        (CLK),
        .RESET      (RESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        tmr_load    = 1'b0;
        tmr_val     = 16'd0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d     = ST_TURNAROUND;
                    shift_d     = TX_BUFFER;
                    bits_left_d = total_clamped;
                    tmr_load    = 1'b1;
                    tmr_val     = TURN_CYC;
                end
            end
            ST_TURNAROUND: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (bits_left_q == 8'd0) begin
                        state_d = ST_STOP;
                        tmr_val = STOP_CYC;
                    end else begin
                        state_d = ST_BIT_LOW;
                        tmr_val = low_cur;
                    end
                end
            end
            ST_BIT_LOW: begin
                if (tmr_tc) begin
                    state_d  = ST_BIT_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = 16'(BIT_CYC - low_cur);
                end
            end
            ST_BIT_HIGH: begin
                if (tmr_tc) begin
                    shift_d     = shift_next;
                    bits_left_d = 8'(bits_left_q - 8'd1);
                    tmr_load    = 1'b1;
                    if (bits_left_d == 8'd0) begin
                        state_d = ST_STOP;
                        tmr_val = STOP_CYC;
                    end else begin
                        // Next bit's low width comes from the post-shift MSB: no gap between bits.
                        state_d = ST_BIT_LOW;
                        tmr_val = low_next;
                    end
                end
            end
            ST_STOP: begin
                if (tmr_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bits_left_q <= 8'd0;
            cmd_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            drive_low_q <= 1'b0;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            cmd_prev_q  <= CMD_DONE;
            armed_q     <= armed_q | ~CMD_DONE;
            // Line outputs are registered off the current state, so the waveform trails the
            // state by one cycle; BUSY follows the next state so it rises on the latch edge.
            drive_low_q <= (state_q == ST_BIT_LOW) || (state_q == ST_STOP);
            busy_q      <= (state_d != ST_IDLE);
            tx_done_q   <= (state_q == ST_DONE);
        end
    end

    assign DRIVE_LOW = drive_low_q;
    assign BUSY      = busy_q;
    assign TX_DONE   = tx_done_q;

endmodule
